ex_mem_ccr_stage: RTL and testbench
===================================

Name: ex_mem_ccr_stage

Overview:
Execute-to-memory pipeline register placed directly downstream of the ALU. It captures the ALU result, flags, store data and control bits into the EX/MEM register. It owns the architectural condition-code register (CCR: bit0 zero, bit1 sign, bit2 carry), updated per instruction through a flag write mask. It also supports conditional-jump flag clearing and single-level CCR save/restore for interrupts.

Parameters:
DATA_W, 32, datapath width (matches ALU result)
REG_ADDR_W, 3, destination register address width
CCR_RST, 3'b000, CCR value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
inValid  in  1  EX holds a real instruction this cycle
aluResult  in  DATA_W  ALU result
carryFlag  in  1  ALU carry
signFlag  in  1  ALU sign
zeroFlag  in  1  ALU zero
flagWrMask  in  3  per-bit CCR write enable {C,S,Z}
storeData  in  DATA_W  register data for memory store
rdAddr  in  REG_ADDR_W  destination register
regWrite  in  1  writeback enable
memRead  in  1  load
memWrite  in  1  store
jmpTaken  in  1  conditional jump resolved taken this cycle
jmpFlagSel  in  2  flag consumed by jump: 0=Z,1=S,2=C,3=none
flagSave  in  1  interrupt entry: copy CCR to shadow
flagRestore  in  1  RTI: copy shadow to CCR
stall  in  1  hold EX/MEM register and CCR
flush  in  1  squash incoming EX instruction
outValid  out  1  EX/MEM slot valid
memAddrOrResult  out  DATA_W  registered aluResult
memStoreData  out  DATA_W  registered storeData
outRdAddr  out  REG_ADDR_W  registered rdAddr
outRegWrite  out  1  registered regWrite (0 when bubble)
outMemRead  out  1  registered memRead (0 when bubble)
outMemWrite  out  1  registered memWrite (0 when bubble)
ccr  out  3  architectural flags {C,S,Z}
ccrShadow  out  3  saved flags

Behaviour:
- All state updates on the rising edge of clk. Reset is sampled synchronously with rst==0 and has top priority. On reset: outValid=0, data outputs=0, outRdAddr=0, all out* control bits=0, ccr=CCR_RST, ccrShadow=CCR_RST.
- Pipeline register priority, highest first: reset > flush > stall > load.
  - flush=1: next outValid=0 and all out* control bits=0. Data fields may take any value.
  - stall=1 (no flush): all EX/MEM fields hold.
  - Otherwise: load. outValid<=inValid. If inValid=0, control bits go to 0.
- Latency: exactly 1 cycle from EX inputs to registered outputs. There is no combinational input-to-output path except that ccr and ccrShadow are register outputs.
- The instruction commits when inValid=1, flush=0 and stall=0. Only a committing instruction may modify the CCR.
- CCR next-value priority:
  1. flagRestore=1: ccr<=ccrShadow. This overrides mask writes and jump clears in the same cycle. Restore is not gated by stall.
  2. Otherwise, if the instruction commits: for each bit i with flagWrMask[i]=1, ccr[i]<=ALU flag i.
  3. Then, if jmpTaken=1 and jmpFlagSel!=3, the selected bit is cleared. The clear wins over a mask write to the same bit.
  4. Otherwise ccr holds.
- flagSave=1: ccrShadow<=ccr using the pre-update value, even if the CCR also updates that cycle.
- flagSave and flagRestore together: the shadow and CCR exchange values (swap).
- Flags depend on nothing but the inputs; the ALU alone defines them. No recomputation of zero or sign happens here.
- Reset asserted mid-stall or mid-flush: the reset state is reached on the next edge. Stall and flush have no residual effect.

Test Plan:
- rst=0 for 2 cycles with all inputs at 1 -> outValid=0, ccr=000, ccrShadow=000. Release rst: first edge with inValid=1, aluResult=32'h1234_5678, rdAddr=5, regWrite=1 -> next cycle memAddrOrResult=32'h1234_5678, outRdAddr=5, outRegWrite=1, outValid=1.
- aluResult=0, zero=1, carry=1, sign=0, flagWrMask=3'b101 -> ccr=3'b101. Next instruction with sign=1 and flagWrMask=3'b000 -> ccr stays 3'b101.
- stall=1 for 3 cycles with changing inputs and flagWrMask=3'b111 -> outputs and ccr frozen at prior values. Drop stall -> the held instruction loads.
- flush=1 and stall=1 with memWrite=1 and flagWrMask=3'b111 -> outValid=0, outMemWrite=0, ccr unchanged.
- ccr=3'b001, jmpTaken=1, jmpFlagSel=0, with a committing instruction writing Z=1 -> ccr=3'b000.
- ccr=3'b110, flagSave=1 -> ccrShadow=3'b110. Then an ALU write sets ccr=3'b001. Then flagRestore=1 together with flagWrMask=3'b111 -> ccr=3'b110. flagSave and flagRestore together with ccr=3'b010 and shadow=3'b100 -> ccr=3'b100, shadow=3'b010.

Source files
------------

// File: rtl/ex_mem_ccr_stage.sv
// EX/MEM pipeline register fed by the ALU. It also owns the architectural
// condition-code register {C,S,Z} and a single-level shadow copy used across interrupts.
module ex_mem_ccr_stage #(
  parameter int         DATA_W     = 32,
  parameter int         REG_ADDR_W = 3,
  parameter logic [2:0] CCR_RST    = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  input  logic [DATA_W-1:0]     aluResult,
  input  logic                  carryFlag,
  input  logic                  signFlag,
  input  logic                  zeroFlag,
  input  logic [2:0]            flagWrMask,
  input  logic [DATA_W-1:0]     storeData,
  input  logic [REG_ADDR_W-1:0] rdAddr,
  input  logic                  regWrite,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  jmpTaken,
  input  logic [1:0]            jmpFlagSel,
  input  logic                  flagSave,
  input  logic                  flagRestore,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  outValid,
  output logic [DATA_W-1:0]     memAddrOrResult,
  output logic [DATA_W-1:0]     memStoreData,
  output logic [REG_ADDR_W-1:0] outRdAddr,
  output logic                  outRegWrite,
  output logic                  outMemRead,
  output logic                  outMemWrite,
  output logic [2:0]            ccr,
  output logic [2:0]            ccrShadow
);

  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic [DATA_W-1:0]     store_q, store_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  regwr_q, regwr_d;
  logic                  memrd_q, memrd_d;
  logic                  memwr_q, memwr_d;
  logic [2:0]            ccr_q, ccr_d;
  logic [2:0]            shadow_q, shadow_d;

  logic                  commit_s;
  logic [2:0]            alu_flags_s;
  logic [2:0]            clr_mask_s;
  logic [2:0]            ccr_wr_s;

  assign commit_s    = inValid & ~flush & ~stall;
  assign alu_flags_s = {carryFlag, signFlag, zeroFlag};
  assign ccr_wr_s    = (ccr_q & ~flagWrMask) | (alu_flags_s & flagWrMask);

  // Pipeline register next state: flush squashes, stall holds, otherwise load.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    store_d  = store_q;
    rd_d     = rd_q;
    regwr_d  = regwr_q;
    memrd_d  = memrd_q;
    memwr_d  = memwr_q;
    if (flush) begin
      valid_d = 1'b0;
      regwr_d = 1'b0;
      memrd_d = 1'b0;
      memwr_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d  = inValid;
      result_d = aluResult;
      store_d  = storeData;
      rd_d     = rdAddr;
      regwr_d  = regWrite & inValid;
      memrd_d  = memRead & inValid;
      memwr_d  = memWrite & inValid;
    end
  end

  // Decode which flag a taken conditional jump consumes and must clear.
  always_comb begin
    clr_mask_s = 3'b000;
    if (jmpTaken) begin
      case (jmpFlagSel)
        2'd0:    clr_mask_s = 3'b001;
        2'd1:    clr_mask_s = 3'b010;
        2'd2:    clr_mask_s = 3'b100;
        default: clr_mask_s = 3'b000;
      endcase
    end else begin
      clr_mask_s = 3'b000;
    end
  end

  // CCR next state: restore beats everything; only commits write or clear flags.
  always_comb begin
    ccr_d    = ccr_q;
    shadow_d = shadow_q;
    if (flagRestore) begin
      ccr_d = shadow_q;
    end else if (commit_s) begin
      ccr_d = ccr_wr_s & ~clr_mask_s;
    end else begin
      ccr_d = ccr_q;
    end
    // Save copies the pre-update value, so save+restore swaps.
    if (flagSave) begin
      shadow_d = ccr_q;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      result_q <= {DATA_W{1'b0}};
      store_q  <= {DATA_W{1'b0}};
      rd_q     <= {REG_ADDR_W{1'b0}};
      regwr_q  <= 1'b0;
      memrd_q  <= 1'b0;
      memwr_q  <= 1'b0;
      ccr_q    <= CCR_RST;
      shadow_q <= CCR_RST;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      regwr_q  <= regwr_d;
      memrd_q  <= memrd_d;
      memwr_q  <= memwr_d;
      ccr_q    <= ccr_d;
      shadow_q <= shadow_d;
    end
  end

  assign outValid        = valid_q;
  assign memAddrOrResult = result_q;
  assign memStoreData    = store_q;
  assign outRdAddr       = rd_q;
  assign outRegWrite     = regwr_q;
  assign outMemRead      = memrd_q;
  assign outMemWrite     = memwr_q;
  assign ccr             = ccr_q;
  assign ccrShadow       = shadow_q;

endmodule

// File: tb/tb_ex_mem_ccr_stage.sv
// Directed bench for ex_mem_ccr_stage: a behavioural model pushes expected
// post-edge state into a queue, which is popped and compared after each edge.
module tb_ex_mem_ccr_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [31:0] aluResult;
  logic        carryFlag, signFlag, zeroFlag;
  logic [2:0]  flagWrMask;
  logic [31:0] storeData;
  logic [2:0]  rdAddr;
  logic        regWrite, memRead, memWrite;
  logic        jmpTaken;
  logic [1:0]  jmpFlagSel;
  logic        flagSave, flagRestore, stall, flush;
  logic        outValid;
  logic [31:0] memAddrOrResult, memStoreData;
  logic [2:0]  outRdAddr;
  logic        outRegWrite, outMemRead, outMemWrite;
  logic [2:0]  ccr, ccrShadow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [31:0] sd;
    logic [2:0]  rd;
    logic        rw, mr, mw;
    logic [2:0]  ccr;
    logic [2:0]  sh;
  } exp_t;

  exp_t m;
  exp_t sb[$];

  ex_mem_ccr_stage #(.DATA_W(32), .REG_ADDR_W(3), .CCR_RST(3'b000)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .aluResult(aluResult),
    .carryFlag(carryFlag), .signFlag(signFlag), .zeroFlag(zeroFlag),
    .flagWrMask(flagWrMask), .storeData(storeData), .rdAddr(rdAddr),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .jmpTaken(jmpTaken), .jmpFlagSel(jmpFlagSel), .flagSave(flagSave),
    .flagRestore(flagRestore), .stall(stall), .flush(flush),
    .outValid(outValid), .memAddrOrResult(memAddrOrResult),
    .memStoreData(memStoreData), .outRdAddr(outRdAddr),
    .outRegWrite(outRegWrite), .outMemRead(outMemRead),
    .outMemWrite(outMemWrite), .ccr(ccr), .ccrShadow(ccrShadow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inValid = 1'b0; aluResult = 32'h0; storeData = 32'h0; rdAddr = 3'd0;
    carryFlag = 1'b0; signFlag = 1'b0; zeroFlag = 1'b0; flagWrMask = 3'b000;
    regWrite = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    jmpTaken = 1'b0; jmpFlagSel = 2'd3; flagSave = 1'b0; flagRestore = 1'b0;
    stall = 1'b0; flush = 1'b0;
  endtask

  // Advance the model from the current inputs, push, clock, then pop and compare.
  task automatic cyc(input string tag);
    exp_t n, e;
    logic commit;
    logic [2:0] fl;
    n = m;
    fl = {carryFlag, signFlag, zeroFlag};
    commit = inValid && !flush && !stall;
    if (!rst) begin
      n.v = 1'b0; n.res = 32'h0; n.sd = 32'h0; n.rd = 3'd0;
      n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.ccr = 3'b000; n.sh = 3'b000;
    end else begin
      if (flush) begin
        n.v = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0;
      end else if (!stall) begin
        n.v = inValid; n.res = aluResult; n.sd = storeData; n.rd = rdAddr;
        n.rw = inValid ? regWrite : 1'b0;
        n.mr = inValid ? memRead : 1'b0;
        n.mw = inValid ? memWrite : 1'b0;
      end
      if (flagRestore) n.ccr = m.sh;
      else if (commit) begin
        for (int i = 0; i < 3; i++) if (flagWrMask[i]) n.ccr[i] = fl[i];
        if (jmpTaken && jmpFlagSel != 2'd3) n.ccr[jmpFlagSel] = 1'b0;
      end
      if (flagSave) n.sh = m.ccr;
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".outValid"}, {31'd0, outValid}, {31'd0, e.v});
    check({tag, ".outRegWrite"}, {31'd0, outRegWrite}, {31'd0, e.rw});
    check({tag, ".outMemRead"}, {31'd0, outMemRead}, {31'd0, e.mr});
    check({tag, ".outMemWrite"}, {31'd0, outMemWrite}, {31'd0, e.mw});
    check({tag, ".ccr"}, {29'd0, ccr}, {29'd0, e.ccr});
    check({tag, ".ccrShadow"}, {29'd0, ccrShadow}, {29'd0, e.sh});
    if (e.v) begin
      check({tag, ".result"}, memAddrOrResult, e.res);
      check({tag, ".storeData"}, memStoreData, e.sd);
      check({tag, ".rdAddr"}, {29'd0, outRdAddr}, {29'd0, e.rd});
    end
  endtask

  task automatic alu_write(input logic [2:0] f, input string tag);
    idle();
    inValid = 1'b1; flagWrMask = 3'b111;
    {carryFlag, signFlag, zeroFlag} = f;
    cyc(tag);
  endtask

  initial begin
    m = '{default: '0};
    // Reset with every input driven high
    rst = 1'b0;
    inValid = 1'b1; aluResult = 32'hFFFF_FFFF; storeData = 32'hFFFF_FFFF; rdAddr = 3'd7;
    carryFlag = 1'b1; signFlag = 1'b1; zeroFlag = 1'b1; flagWrMask = 3'b111;
    regWrite = 1'b1; memRead = 1'b1; memWrite = 1'b1; jmpTaken = 1'b1; jmpFlagSel = 2'd3;
    flagSave = 1'b1; flagRestore = 1'b1; stall = 1'b1; flush = 1'b1;
    #1;
    cyc("rst0");
    cyc("rst1");
    check("rst.ccr_lit", {29'd0, ccr}, 32'd0);
    check("rst.valid_lit", {31'd0, outValid}, 32'd0);

    rst = 1'b1;
    idle();
    inValid = 1'b1; aluResult = 32'h1234_5678; rdAddr = 3'd5; regWrite = 1'b1; storeData = 32'hCAFE_0001;
    cyc("first");
    check("first.result_lit", memAddrOrResult, 32'h1234_5678);
    check("first.rd_lit", {29'd0, outRdAddr}, 32'd5);

    idle();
    inValid = 1'b1; zeroFlag = 1'b1; carryFlag = 1'b1; flagWrMask = 3'b101; memRead = 1'b1; rdAddr = 3'd2;
    cyc("mask101");
    check("mask101.ccr_lit", {29'd0, ccr}, 32'd5);
    idle();
    inValid = 1'b1; signFlag = 1'b1; aluResult = 32'h8000_0000; memWrite = 1'b1; storeData = 32'h55AA_55AA;
    cyc("mask000");
    check("mask000.ccr_lit", {29'd0, ccr}, 32'd5);

    // Stall for three cycles with changing inputs
    for (int i = 0; i < 3; i++) begin
      idle();
      stall = 1'b1; inValid = 1'b1; flagWrMask = 3'b111; regWrite = 1'b1;
      aluResult = 32'hA000_0000 + i; rdAddr = 3'(i + 1); {carryFlag, signFlag, zeroFlag} = 3'(i + 2);
      cyc("stall");
    end
    check("stall.ccr_lit", {29'd0, ccr}, 32'd5);
    stall = 1'b0;
    cyc("unstall");
    check("unstall.result_lit", memAddrOrResult, 32'hA000_0002);

    idle();
    flush = 1'b1; stall = 1'b1; inValid = 1'b1; memWrite = 1'b1; flagWrMask = 3'b111;
    cyc("flush_stall");
    check("flush.ccr_lit", {29'd0, ccr}, 32'd4);

    idle();
    inValid = 1'b0; regWrite = 1'b1; memWrite = 1'b1; flagWrMask = 3'b111; zeroFlag = 1'b1;
    cyc("bubble");

    alu_write(3'b001, "set001");
    idle();
    inValid = 1'b1; jmpTaken = 1'b1; jmpFlagSel = 2'd0; zeroFlag = 1'b1; flagWrMask = 3'b001;
    cyc("jmp_z");
    check("jmp_z.ccr_lit", {29'd0, ccr}, 32'd0);
    alu_write(3'b111, "set111");
    idle();
    inValid = 1'b1; jmpTaken = 1'b1; jmpFlagSel = 2'd2;
    cyc("jmp_c");
    idle();
    inValid = 1'b1; jmpTaken = 1'b1; jmpFlagSel = 2'd3;
    cyc("jmp_none");

    alu_write(3'b110, "set110");
    idle();
    flagSave = 1'b1;
    cyc("save");
    check("save.shadow_lit", {29'd0, ccrShadow}, 32'd6);
    alu_write(3'b001, "set001b");
    idle();
    flagRestore = 1'b1; inValid = 1'b1; flagWrMask = 3'b111; {carryFlag, signFlag, zeroFlag} = 3'b111;
    cyc("restore");
    check("restore.ccr_lit", {29'd0, ccr}, 32'd6);

    alu_write(3'b100, "set100");
    idle();
    flagSave = 1'b1;
    cyc("save100");
    alu_write(3'b010, "set010");
    idle();
    flagSave = 1'b1; flagRestore = 1'b1;
    cyc("swap");
    check("swap.ccr_lit", {29'd0, ccr}, 32'd4);
    check("swap.shadow_lit", {29'd0, ccrShadow}, 32'd2);

    idle();
    stall = 1'b1; flagRestore = 1'b1;
    cyc("restore_stall");

    idle();
    stall = 1'b1; inValid = 1'b1; regWrite = 1'b1;
    cyc("pre_rst_stall");
    rst = 1'b0;
    cyc("rst_in_stall");
    rst = 1'b1; stall = 1'b0; flush = 1'b0; inValid = 1'b0;
    cyc("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
